operand_stage: RTL

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/operand_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register-file read, EX/MEM and MEM/WB forwarding,
// load/ALU-use hazard detection with stall, flush bubbles and a saturating stall counter.
module operand_stage #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned MUX_CNTRL = 5,
  parameter int unsigned CTRL_W    = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 IdValid,
  input  logic [MUX_CNTRL-1:0] IdSrcA,
  input  logic [MUX_CNTRL-1:0] IdSrcB,
  input  logic                 IdUsesB,
  input  logic [MUX_CNTRL-1:0] IdDest,
  input  logic                 IdRegWrite,
  input  logic                 IdMemRead,
  input  logic [REG_WIDTH-1:0] IdImm,
  input  logic [CTRL_W-1:0]    IdCtrl,
  output logic [MUX_CNTRL-1:0] RfSrcA,
  output logic [MUX_CNTRL-1:0] RfSrcB,
  input  logic [REG_WIDTH-1:0] RfDataA,
  input  logic [REG_WIDTH-1:0] RfDataB,
  input  logic                 ExMemRegWrite,
  input  logic                 ExMemMemRead,
  input  logic [MUX_CNTRL-1:0] ExMemDest,
  input  logic [REG_WIDTH-1:0] ExMemResult,
  input  logic                 MemWbRegWrite,
  input  logic [MUX_CNTRL-1:0] MemWbDest,
  input  logic [REG_WIDTH-1:0] MemWbData,
  input  logic                 Flush,
  output logic                 Stall,
  output logic                 ExValid,
  output logic                 ExRegWrite,
  output logic                 ExMemRead,
  output logic [MUX_CNTRL-1:0] ExDest,
  output logic [REG_WIDTH-1:0] ExOpA,
  output logic [REG_WIDTH-1:0] ExOpB,
  output logic [REG_WIDTH-1:0] ExImm,
  output logic [CTRL_W-1:0]    ExCtrl,
  output logic [15:0]          StallCount
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 ex_valid_q, ex_valid_d;
  logic                 ex_reg_write_q, ex_reg_write_d;
  logic                 ex_mem_read_q, ex_mem_read_d;
  logic [MUX_CNTRL-1:0] ex_dest_q, ex_dest_d;
  logic [REG_WIDTH-1:0] ex_op_a_q, ex_op_a_d;
  logic [REG_WIDTH-1:0] ex_op_b_q, ex_op_b_d;
  logic [REG_WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [CTRL_W-1:0]    ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]     stall_count_q, stall_count_d;
  logic [REG_WIDTH-1:0] op_a, op_b;
  logic                 hazard;

  // Operand select: zero register, then EX/MEM ALU result, then MEM/WB, then register file.
  function automatic logic [REG_WIDTH-1:0] fwd_sel(
    input logic [MUX_CNTRL-1:0] src,
    input logic [REG_WIDTH-1:0] rf,
    input logic                 xm_rw,
    input logic                 xm_mr,
    input logic [MUX_CNTRL-1:0] xm_dest,
    input logic [REG_WIDTH-1:0] xm_res,
    input logic                 mw_rw,
    input logic [MUX_CNTRL-1:0] mw_dest,
    input logic [REG_WIDTH-1:0] mw_data
  );
    if (src == MUX_CNTRL'(0))                        return '0;
    else if (xm_rw && !xm_mr && (xm_dest == src))    return xm_res;
    else if (mw_rw && (mw_dest == src))              return mw_data;
    else                                             return rf;
  endfunction

  // A source depends on an instruction whose value is not yet forwardable.
  function automatic logic dep(
    input logic [MUX_CNTRL-1:0] src,
    input logic                 ex_v,
    input logic                 ex_rw,
    input logic [MUX_CNTRL-1:0] ex_dest,
    input logic                 xm_rw,
    input logic                 xm_mr,
    input logic [MUX_CNTRL-1:0] xm_dest
  );
    return (src != MUX_CNTRL'(0)) &&
           ((ex_v && ex_rw && (ex_dest == src)) || (xm_rw && xm_mr && (xm_dest == src)));
  endfunction

  assign RfSrcA = IdSrcA;
  assign RfSrcB = IdSrcB;

  always_comb begin
    op_a = fwd_sel(IdSrcA, RfDataA, ExMemRegWrite, ExMemMemRead, ExMemDest, ExMemResult,
                   MemWbRegWrite, MemWbDest, MemWbData);
    op_b = fwd_sel(IdSrcB, RfDataB, ExMemRegWrite, ExMemMemRead, ExMemDest, ExMemResult,
                   MemWbRegWrite, MemWbDest, MemWbData);
    hazard = IdValid &&
             (dep(IdSrcA, ex_valid_q, ex_reg_write_q, ex_dest_q,
                  ExMemRegWrite, ExMemMemRead, ExMemDest) ||
              (IdUsesB && dep(IdSrcB, ex_valid_q, ex_reg_write_q, ex_dest_q,
                              ExMemRegWrite, ExMemMemRead, ExMemDest)));
  end

  assign Stall = hazard && !Flush && !Reset;

  // Next-state: bubble on flush or stall (payload held), otherwise accept decode slot.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_dest_d      = ex_dest_q;
    ex_op_a_d      = ex_op_a_q;
    ex_op_b_d      = ex_op_b_q;
    ex_imm_d       = ex_imm_q;
    ex_ctrl_d      = ex_ctrl_q;
    stall_count_d  = stall_count_q;
    if (Flush || Stall) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else begin
      ex_valid_d     = IdValid;
      ex_reg_write_d = IdRegWrite && IdValid;
      ex_mem_read_d  = IdMemRead && IdValid;
      ex_dest_d      = IdDest;
      ex_op_a_d      = op_a;
      ex_op_b_d      = op_b;
      ex_imm_d       = IdImm;
      ex_ctrl_d      = IdCtrl;
    end
    if (Stall && (stall_count_q != CNT_MAX)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_dest_q      <= '0;
      ex_op_a_q      <= '0;
      ex_op_b_q      <= '0;
      ex_imm_q       <= '0;
      ex_ctrl_q      <= '0;
      stall_count_q  <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_dest_q      <= ex_dest_d;
      ex_op_a_q      <= ex_op_a_d;
      ex_op_b_q      <= ex_op_b_d;
      ex_imm_q       <= ex_imm_d;
      ex_ctrl_q      <= ex_ctrl_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign ExValid    = ex_valid_q;
  assign ExRegWrite = ex_reg_write_q;
  assign ExMemRead  = ex_mem_read_q;
  assign ExDest     = ex_dest_q;
  assign ExOpA      = ex_op_a_q;
  assign ExOpB      = ex_op_b_q;
  assign ExImm      = ex_imm_q;
  assign ExCtrl     = ex_ctrl_q;
  assign StallCount = stall_count_q;

endmodule
